// File: rtl/dff_chain_pkg.sv
// -----------------------------------------------------------------------------
// dff_chain_pkg
// Shared helpers for the dff_chain elastic register pipeline.
//   occ_w    : width of the occupancy counter for a given stage count.
//   inv_mask : expands a per-channel inversion mask into a full-width XOR
//              vector (channel c occupies bits [c*width +: width]).
// inv_mask returns a fixed-width vector. Callers keep only the low
// CHANNELS*WIDTH bits.
// -----------------------------------------------------------------------------
package dff_chain_pkg;

  // Upper bounds for the fixed-width helper vectors.
  localparam int INV_MAX_CH = 256;
  localparam int MASK_MAX_W = 4096;

  // Number of bits needed to count 0..depth valid stages.
  function automatic int occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Channel c becomes all-ones when invert[c] is set, and all-zeros otherwise.
  function automatic logic [MASK_MAX_W-1:0] inv_mask(
    input logic [INV_MAX_CH-1:0] invert,
    input int                    width,
    input int                    channels
  );
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int c = 0; c < channels; c++) begin
      for (int b = 0; b < width; b++) begin
        m[c*width + b] = invert[c];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/dff_chain_stage.sv
// -----------------------------------------------------------------------------
// dff_chain_stage
// One elastic pipeline slot: a valid flag plus a data register.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset. Clears both valid and data.
//   load  : capture d_in and mark the slot valid. Takes priority over clear.
//   clear : drop the valid flag. The data register is left untouched.
//   d_in  : data offered by the upstream slot or by the pipeline input.
//   valid : slot holds a live item.
//   data  : stored item.
// -----------------------------------------------------------------------------
module dff_chain_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_in,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // When a slot refills in the same cycle its item leaves, it stays
      // valid and takes the new data.
      valid <= 1'b1;
      data  <= d_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dff_chain.sv
// -----------------------------------------------------------------------------
// dff_chain
// Parametrised multi-channel elastic register pipeline. It has valid/ready
// flow control with bubble collapse, a synchronous flush, a per-channel
// static output inversion and an occupancy count.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset. Empties the pipeline and
//               zeroes the data.
//   flush     : synchronous clear of all valid bits. No input is accepted
//               while it is high.
//   in_valid  : in_data is valid
//   in_ready  : the pipeline accepts in_data this cycle
//   in_data   : CHANNELS*WIDTH bits. Channel c is at [c*WIDTH +: WIDTH].
//   out_valid : the last stage holds valid data
//   out_ready : the sink accepts out_data
//   out_data  : last-stage data XORed with the INVERT channel mask
//   occupancy : number of valid stages (0..DEPTH)
// -----------------------------------------------------------------------------
module dff_chain
  import dff_chain_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter int                  CHANNELS = 2,
  parameter int                  DEPTH    = 3,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [occ_w(DEPTH)-1:0]      occupancy
);

  localparam int N     = CHANNELS * WIDTH;
  localparam int OCC_W = occ_w(DEPTH);

  // Widen the channel mask to the helper width, then keep only the live bits.
  localparam logic [INV_MAX_CH-1:0] INV_EXT  = INV_MAX_CH'(INVERT);
  localparam logic [MASK_MAX_W-1:0] INV_FULL = inv_mask(INV_EXT, WIDTH, CHANNELS);
  localparam logic [N-1:0]          INV_VEC  = INV_FULL[N-1:0];

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [N-1:0]     data [DEPTH];
  logic             accept;

  // Move chain, evaluated from the output side back to the input. A stage
  // moves when its successor is empty or is itself moving. This lets items
  // close up into bubbles even when the sink stalls.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = valid[DEPTH-1] && out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = valid[i] && (!valid[i+1] || mv[i+1]);
    end
  end

  // in_ready depends only on out_ready, flush and stage state. It never
  // depends on in_valid.
  assign in_ready = !flush && (!valid[0] || mv[0]);
  assign accept   = in_valid && in_ready;

  // Stage i>0 loads when stage i-1 moves. mv[i-1] already implies that
  // stage i is empty or moving. Flush suppresses every load and clears
  // every valid bit. A sink handshake in the same cycle still completes
  // at the sink.
  always_comb begin
    load  = '0;
    clear = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) begin
        load[i] = accept;
      end else begin
        load[i] = mv[i-1] && !flush;
      end
      clear[i] = flush || mv[i];
    end
  end

  // ---- stage boundary: DEPTH registered slots, stage 0 on the input side ----
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [N-1:0] d_in;
    if (g == 0) begin : g_head
      assign d_in = in_data;
    end else begin : g_body
      assign d_in = data[g-1];
    end

    dff_chain_stage #(
      .W (N)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .clear (clear[g]),
      .d_in  (d_in),
      .valid (valid[g]),
      .data  (data[g])
    );
  end

  // Output is taken combinationally from the last register. The inversion
  // is applied only here, so the stored data is never inverted.
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1] ^ INV_VEC;

  // Occupancy is a popcount of the registered valid bits. It follows every
  // clock edge and reacts to an asynchronous reset at once.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end

endmodule

// File: tb/tb_dff_chain.sv
module tb_dff_chain;

  localparam int                WIDTH    = 8;
  localparam int                CHANNELS = 2;
  localparam int                DEPTH    = 3;
  localparam logic [1:0]        INVERT   = 2'b10;
  localparam int                N        = WIDTH * CHANNELS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  dff_chain #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH),
    .INVERT   (INVERT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0000FF00);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    #1 rst = 1'b0;

    // Three items streamed back to back with the sink always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0102;
    tick();
    in_data = 16'h0304;
    tick();
    check("stream_lat_not_yet", 32'(out_valid), 32'd0);
    in_data = 16'h0506;
    tick();
    check("stream_valid_1", 32'(out_valid), 32'd1);
    check("stream_data_1",  32'(out_data),  32'h0000FE02);
    in_valid = 1'b0;
    tick();
    check("stream_data_2",  32'(out_data),  32'h0000FC04);
    tick();
    check("stream_data_3",  32'(out_data),  32'h0000FA06);
    tick();
    check("stream_drained_valid", 32'(out_valid), 32'd0);
    check("stream_drained_occ",   32'(occupancy), 32'd0);

    // Backpressure: fill the pipe with the sink stalled, then release it.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    check("bp_ready_empty", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'h2222;
    tick();
    in_data = 16'h3333;
    tick();
    in_data = 16'h4444;
    check("bp_occ_full",      32'(occupancy), 32'd3);
    check("bp_ready_full",    32'(in_ready),  32'd0);
    check("bp_head_data",     32'(out_data),  32'h0000EE11);
    tick();
    check("bp_occ_hold",      32'(occupancy), 32'd3);
    check("bp_data_hold",     32'(out_data),  32'h0000EE11);
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(in_ready),  32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out_2", 32'(out_data), 32'h0000DD22);
    tick();
    check("bp_out_3", 32'(out_data), 32'h0000CC33);
    tick();
    check("bp_out_4", 32'(out_data), 32'h0000BB44);
    check("bp_out_4_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty_valid", 32'(out_valid), 32'd0);
    check("bp_empty_occ",   32'(occupancy), 32'd0);

    // Bubble collapse: a lone item walks to the output while the sink stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bubble_occ",       32'(occupancy), 32'd1);
    check("bubble_out_valid", 32'(out_valid), 32'd1);
    check("bubble_in_ready",  32'(in_ready),  32'd1);
    check("bubble_out_data",  32'(out_data),  32'h0000AA55);
    out_ready = 1'b1;
    tick();
    check("bubble_drained", 32'(out_valid), 32'd0);

    // Flush with an item offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0A0A;
    tick();
    in_data = 16'h0B0B;
    tick();
    in_data = 16'h0C0C;
    tick();
    check("flush_pre_occ", 32'(occupancy), 32'd3);
    flush   = 1'b1;
    in_data = 16'h0D0D;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_occ",       32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_item_dropped", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset applied between edges with two items in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'h5678;
    tick();
    in_valid = 1'b0;
    check("arst_pre_occ",   32'(occupancy), 32'd2);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_occ",       32'(occupancy), 32'd0);
    check("arst_out_data",  32'(out_data),  32'h0000FF00);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    #1 rst = 1'b0;

    // The pipeline restarts empty after reset, with the normal latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    tick();
    in_valid = 1'b0;
    tick();
    check("restart_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_data",  32'(out_data),  32'h00008877);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_chain.md
Name: dff_chain

Overview:
- Parametrised, multi-channel, elastic register pipeline.
- Next generation of the single-stage dff/inv DUT pair used by the clocking-block benches.
- Adds a stage count, a channel count, a per-channel static output inversion, valid/ready flow control with bubble collapse, a synchronous flush and an occupancy count.
- Serves as the standard DUT for clocking-block skew, backpressure and multi-cycle-latency tests.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 2, number of parallel channels carried by each stage.
- DEPTH, 3, number of register stages (>=1).
- INVERT, '0, CHANNELS-bit mask; bit c=1 inverts channel c at the output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  sink accepts out_data.
- out_data  output  CHANNELS*WIDTH  last-stage data after INVERT mask.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (async, rst=1): all stage valid bits 0, all stage data 0. Therefore out_valid=0, out_data=INVERT-masked zero (channel c = all-ones if INVERT[c]), occupancy=0, in_ready=1. Takes effect immediately, with no clk edge needed.
- Stage i holds valid[i] and data[i]. Stage 0 is the input side; stage DEPTH-1 drives the output.
- Move signal:
  - mv[DEPTH-1] = valid[DEPTH-1] && out_ready.
  - mv[i] = valid[i] && (!valid[i+1] || mv[i+1]).
- Stage i loads on a clk edge when it is empty, or when its own data moves, and its upstream has data to offer:
  - Upstream of stage 0 is in_valid/in_data.
  - Upstream of stage i>0 is stage i-1.
  - Otherwise stage i clears valid if mv[i], else holds.
- in_ready = !valid[0] || mv[0]. This is combinational from out_ready through the chain. No combinational path from in_valid to in_ready.
- Bubble collapse: a valid stage always advances into an empty successor, even when out_ready=0.
- Latency: DEPTH cycles from an accepted input to out_valid when unobstructed. Throughput is 1 item/cycle.
- out_data: data[DEPTH-1] with channel c XORed with {WIDTH{INVERT[c]}}. Purely combinational from the last-stage register. Stage data itself is never inverted.
- Handshake: out_data is held stable while out_valid && !out_ready. in_data is sampled only when in_valid && in_ready.
- flush=1 at a clk edge:
  - All valid bits are cleared. Data registers are not required to clear.
  - in_ready=0 while flush=1, so an input is not accepted; an item offered in that cycle is dropped.
  - An output handshake in the same cycle still completes at the sink; the item is simply not retained.
- flush and rst together: rst dominates.
- occupancy = popcount(valid), registered view, updated each edge. Range 0..DEPTH. Full when occupancy=DEPTH and !out_ready, which makes in_ready=0.
- DEPTH=1: degenerates to one elastic register (skid-free).
- Reset asserted mid-stream: all in-flight items are lost. After deassertion the pipeline restarts empty.

Decomposition:
- Package dff_chain_pkg holds:
  - occupancy width function `occ_w(DEPTH)`;
  - helper `inv_mask(INVERT, WIDTH, CHANNELS)` that returns the full CHANNELS*WIDTH XOR vector.
- One sub-module, dff_chain_stage, is natural. It holds a single valid+data register with load/clear inputs and the async reset. dff_chain instantiates DEPTH of them in a generate loop and computes the mv chain and the output mask.

Test Plan:
- Reset check: rst=1 with defaults (WIDTH=8, CHANNELS=2, INVERT=2'b10) -> out_valid=0, out_data=16'hFF00, occupancy=0, in_ready=1.
- Stream: out_ready=1; push 16'h0102, 16'h0304, 16'h0506 on consecutive edges -> out_valid rises 3 cycles after the first push; out_data = 16'hFE02, 16'hFC04, 16'hFA06 on consecutive cycles.
- Backpressure: out_ready=0, push 4 items -> occupancy reaches 3 and in_ready=0 on the 4th. Raise out_ready -> items exit in order, with no loss or duplication.
- Bubble collapse: push 1 item, out_ready=0, wait 5 cycles -> occupancy=1, out_valid=1, in_ready=1.
- Flush: fill 3 items, assert flush with in_valid=1 for one edge -> occupancy=0, out_valid=0 next cycle, and the offered item never appears.
- Async reset mid-stream: pulse rst between clk edges while occupancy=2 -> out_valid=0 and occupancy=0 immediately, before the next edge.
